ifetch_prefetch_buffer: RTL and testbench
=========================================

Name: ifetch_prefetch_buffer

Overview:
Instruction prefetch stage that sits between instruction memory and the Core101 fetch unit. It generates sequential fetch addresses and issues them over a request/grant/response memory handshake. Returned instructions are buffered with their PC in an in-order FIFO and presented to the IFU through a valid/ready interface. On a branch/jump redirect it flushes the FIFO, discards stale in-flight responses and restarts fetching at the new target.

Parameters:
DEPTH, 4, FIFO entries; also the limit on buffered plus in-flight requests (power of two, >=2)
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clock_in  input  1  clock; all state updates on the rising edge
reset_in  input  1  synchronous, active-low reset
redirect_in  input  1  flush and restart fetch (branch/jump from EX/WB)
redirect_addr_in  input  32  new fetch target; bits [1:0] are ignored
fetch_ready_in  input  1  IFU accepts the head entry this cycle
fetch_valid_out  output  1  head entry valid
fetch_pc_out  output  32  PC of the head entry
fetch_ir_out  output  32  instruction word of the head entry
mem_req_out  output  1  memory request
mem_addr_out  output  32  request address, word aligned
mem_gnt_in  input  1  request accepted this cycle
mem_rvalid_in  input  1  response data valid; responses return in order
mem_rdata_in  input  32  response instruction word

Behaviour:
- Reset (reset_in low at a rising edge):
  - FIFO count = 0, outstanding = 0, drop = 0, state = FETCH, next_pc = RESET_PC.
  - fetch_valid_out = 0; fetch_pc_out and fetch_ir_out = 0.
  - mem_req_out = 0 while reset_in is low.
  - Reset overrides every other input, including in mid-operation.
- State register holds FETCH or DRAIN.
- FETCH state:
  - mem_req_out = (count + outstanding < DEPTH). Use registered values only; no credit is given for a pop in the same cycle.
  - mem_addr_out = next_pc.
  - On mem_req_out & mem_gnt_in: next_pc += 4 (wraps modulo 2^32) and outstanding increments.
  - Once asserted, mem_req_out and mem_addr_out hold stable until granted. The only exceptions are redirect and reset.
- Responses:
  - On mem_rvalid_in with drop == 0: push {pc, mem_rdata_in} into the FIFO and decrement outstanding.
  - The pushed pc comes from a response-PC register. That register is loaded on redirect or reset and increments by 4 per accepted response.
  - Latency: an entry pushed on edge N drives fetch_valid_out starting the cycle after edge N. There is no bypass.
  - mem_rvalid_in while outstanding == 0 is a protocol error. It is ignored and leaves no state change.
- Output side:
  - fetch_valid_out = (count != 0). fetch_pc_out and fetch_ir_out show the head entry.
  - Pop on fetch_valid_out & fetch_ready_in. Push and pop in the same cycle leaves count unchanged.
  - Because of the issue limit, the FIFO never overflows.
- Redirect (redirect_in high at an edge):
  - FIFO cleared (count = 0), including any same-cycle pop or push.
  - next_pc = {redirect_addr_in[31:2], 2'b00}; the response-PC register is loaded with the same value.
  - A request granted in the redirect cycle still counts as in flight.
  - drop = outstanding + (req & gnt) − rvalid, where rvalid is mem_rvalid_in in that cycle. outstanding is set to the same value.
  - If drop != 0, state = DRAIN; otherwise state = FETCH.
- DRAIN state:
  - mem_req_out = 0.
  - Each mem_rvalid_in decrements drop and outstanding; the data is discarded.
  - When drop reaches 0, return to FETCH. The first request is issued the following cycle.
  - A redirect during DRAIN reloads next_pc. drop is kept equal to the remaining outstanding count.
- Counters are sized clog2(DEPTH)+1 bits and never exceed DEPTH.

Test Plan:
- Reset then streaming (RESET_PC=0, gnt=1 always, rvalid one cycle after gnt, ready=1): mem_addr_out goes 0x0, 0x4, 0x8 on consecutive cycles. The first fetch_valid_out appears 2 cycles after the first grant with pc=0x0 and ir equal to the returned word. PCs then step by 4 each cycle.
- Backpressure (DEPTH=4, ready=0): exactly 4 grants occur, then mem_req_out = 0 with fetch_valid_out = 1. When ready goes to 1, one pop per cycle occurs and requests resume. The output order is 0x0, 0x4, 0x8, 0xC.
- Grant stall (gnt=0 for 3 cycles): mem_req_out = 1 and mem_addr_out = 0x8 are held constant for all 3 cycles. The address advances to 0xC only after the grant.
- Redirect with 2 outstanding, to 0x103: the FIFO empties and state goes to DRAIN. The next 2 rvalid responses are discarded with fetch_valid_out = 0. The next request carries mem_addr_out = 0x100, and the first new entry has pc = 0x100.
- Redirect coinciding with grant and rvalid (outstanding=1): drop = 1. Exactly one further response is discarded.
- Reset asserted mid-stream with a full FIFO: the next cycle shows fetch_valid_out = 0 and outstanding = 0. After release, the first request is to RESET_PC.

Source files
------------

// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch stage: issues sequential word fetches, buffers in-order
// responses with their PC, and flushes/drains stale responses on redirect.
module ifetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_addr_in,
  input  logic        fetch_ready_in,
  output logic        fetch_valid_out,
  output logic [31:0] fetch_pc_out,
  output logic [31:0] fetch_ir_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_gnt_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [31:0]     next_pc_q, next_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [31:0]     pc_mem [DEPTH];
  logic [31:0]     ir_mem [DEPTH];

  logic [CW:0]     inflight_c;
  logic            req_c, grant_c, rsp_c, push_c, pop_c;
  logic [31:0]     target_c;

  // Next-state logic for issue, response accounting, FIFO pointers and drain
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    drop_d        = drop_q;
    head_d        = head_q;
    tail_d        = tail_q;
    next_pc_d     = next_pc_q;
    resp_pc_d     = resp_pc_q;

    inflight_c    = {1'b0, count_q} + {1'b0, outstanding_q};
    req_c         = reset_in && (state_q == FETCH) && (inflight_c < (CW+1)'(DEPTH));
    grant_c       = req_c && mem_gnt_in;
    rsp_c         = mem_rvalid_in && (outstanding_q != '0);
    push_c        = rsp_c && (drop_q == '0);
    pop_c         = (count_q != '0) && fetch_ready_in;
    target_c      = {redirect_addr_in[31:2], 2'b00};
    outstanding_d = outstanding_q + CW'(grant_c) - CW'(rsp_c);

    if (redirect_in) begin
      // Every request still in flight after this edge must be discarded
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      next_pc_d = target_c;
      resp_pc_d = target_c;
      drop_d    = outstanding_d;
      state_d   = (outstanding_d != '0) ? DRAIN : FETCH;
    end else begin
      if (grant_c) next_pc_d = next_pc_q + 32'd4;
      if (push_c) begin
        tail_d    = tail_q + AW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop_c) head_d = head_q + AW'(1);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
      if (rsp_c && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if ((state_q == DRAIN) && (drop_d == '0)) state_d = FETCH;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q       <= FETCH;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      next_pc_q     <= RESET_PC;
      resp_pc_q     <= RESET_PC;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      next_pc_q     <= next_pc_d;
      resp_pc_q     <= resp_pc_d;
    end
  end

  // FIFO storage; no reset needed since count gates visibility
  always_ff @(posedge clock_in) begin
    if (reset_in && push_c && !redirect_in) begin
      pc_mem[tail_q] <= resp_pc_q;
      ir_mem[tail_q] <= mem_rdata_in;
    end
  end

  assign fetch_valid_out = (count_q != '0);
  assign fetch_pc_out    = fetch_valid_out ? pc_mem[head_q] : 32'h0;
  assign fetch_ir_out    = fetch_valid_out ? ir_mem[head_q] : 32'h0;
  assign mem_req_out     = req_c;
  assign mem_addr_out    = next_pc_q;

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Directed bench for ifetch_prefetch_buffer with an in-order memory responder.
module tb_ifetch_prefetch_buffer;

  logic        clk;
  logic        reset_in;
  logic        redirect_in;
  logic [31:0] redirect_addr_in;
  logic        fetch_ready_in;
  logic        fetch_valid_out;
  logic [31:0] fetch_pc_out;
  logic [31:0] fetch_ir_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_gnt_in;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;

  int          checks = 0;
  int          fails  = 0;
  int          grants = 0;
  bit          auto_rv;
  bit          man_rv;
  logic [31:0] pend [$];

  ifetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock_in         (clk),
    .reset_in         (reset_in),
    .redirect_in      (redirect_in),
    .redirect_addr_in (redirect_addr_in),
    .fetch_ready_in   (fetch_ready_in),
    .fetch_valid_out  (fetch_valid_out),
    .fetch_pc_out     (fetch_pc_out),
    .fetch_ir_out     (fetch_ir_out),
    .mem_req_out      (mem_req_out),
    .mem_addr_out     (mem_addr_out),
    .mem_gnt_in       (mem_gnt_in),
    .mem_rvalid_in    (mem_rvalid_in),
    .mem_rdata_in     (mem_rdata_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive the response, record grants, advance to edge+1
  task automatic cyc();
    logic        seen;
    logic        rv;
    logic [31:0] a;
    #1;
    rv = auto_rv ? (pend.size() != 0) : man_rv;
    mem_rvalid_in = rv;
    mem_rdata_in  = (pend.size() != 0) ? word(pend[0]) : 32'h0;
    #1;
    seen = mem_req_out && mem_gnt_in;
    a    = mem_addr_out;
    @(posedge clk);
    #1;
    if (!reset_in) begin
      pend.delete();
    end else begin
      if (rv && pend.size() != 0) void'(pend.pop_front());
      if (seen) begin
        pend.push_back(a);
        grants++;
      end
    end
    mem_rvalid_in = 1'b0;
  endtask

  task automatic do_reset();
    reset_in = 1'b0; auto_rv = 1'b1; man_rv = 1'b0;
    mem_gnt_in = 1'b0; fetch_ready_in = 1'b0; redirect_in = 1'b0;
    cyc();
    cyc();
    reset_in = 1'b1;
    grants = 0;
  endtask

  initial begin
    reset_in = 1'b0; redirect_in = 1'b0; redirect_addr_in = 32'h0;
    fetch_ready_in = 1'b0; mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0;
    mem_rdata_in = 32'h0; auto_rv = 1'b1; man_rv = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_valid", 32'(fetch_valid_out), 32'd0);
    chk("rst_pc", fetch_pc_out, 32'h0);
    chk("rst_ir", fetch_ir_out, 32'h0);
    chk("rst_req", 32'(mem_req_out), 32'd0);
    chk("rst_outstanding", 32'(dut.outstanding_q), 32'd0);
    reset_in = 1'b1;

    // Spurious rvalid with nothing outstanding is ignored
    auto_rv = 1'b0; man_rv = 1'b1;
    cyc();
    man_rv = 1'b0; auto_rv = 1'b1;
    chk("spurious_valid", 32'(fetch_valid_out), 32'd0);
    chk("spurious_addr", mem_addr_out, 32'h0);

    // Streaming
    mem_gnt_in = 1'b1; fetch_ready_in = 1'b1;
    #1;
    chk("stream_req0", 32'(mem_req_out), 32'd1);
    chk("stream_addr0", mem_addr_out, 32'h0);
    cyc();
    chk("stream_addr1", mem_addr_out, 32'h4);
    chk("stream_valid_early", 32'(fetch_valid_out), 32'd0);
    cyc();
    chk("stream_valid0", 32'(fetch_valid_out), 32'd1);
    chk("stream_pc0", fetch_pc_out, 32'h0);
    chk("stream_ir0", fetch_ir_out, word(32'h0));
    chk("stream_addr2", mem_addr_out, 32'h8);
    cyc();
    chk("stream_pc1", fetch_pc_out, 32'h4);
    chk("stream_ir1", fetch_ir_out, word(32'h4));
    chk("stream_addr3", mem_addr_out, 32'hC);
    cyc();
    chk("stream_pc2", fetch_pc_out, 32'h8);

    // Backpressure: issue limit stops requests at DEPTH
    do_reset();
    mem_gnt_in = 1'b1; fetch_ready_in = 1'b0;
    repeat (6) cyc();
    chk("bp_grants", 32'(grants), 32'd4);
    chk("bp_req", 32'(mem_req_out), 32'd0);
    chk("bp_valid", 32'(fetch_valid_out), 32'd1);
    chk("bp_pc0", fetch_pc_out, 32'h0);
    fetch_ready_in = 1'b1;
    #1;
    chk("bp_no_credit", 32'(mem_req_out), 32'd0);
    cyc();
    chk("bp_pc1", fetch_pc_out, 32'h4);
    chk("bp_req_resume", 32'(mem_req_out), 32'd1);
    chk("bp_addr_resume", mem_addr_out, 32'h10);
    cyc();
    chk("bp_pc2", fetch_pc_out, 32'h8);
    cyc();
    chk("bp_pc3", fetch_pc_out, 32'hC);
    cyc();
    chk("bp_pc4", fetch_pc_out, 32'h10);

    // Grant stall holds request and address
    do_reset();
    mem_gnt_in = 1'b1; fetch_ready_in = 1'b1;
    cyc();
    cyc();
    mem_gnt_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 32'(mem_req_out), 32'd1);
      chk("stall_addr", mem_addr_out, 32'h8);
      cyc();
    end
    chk("stall_addr_end", mem_addr_out, 32'h8);
    mem_gnt_in = 1'b1;
    cyc();
    chk("stall_addr_next", mem_addr_out, 32'hC);

    // Redirect with two outstanding requests
    do_reset();
    auto_rv = 1'b0; man_rv = 1'b0;
    mem_gnt_in = 1'b1; fetch_ready_in = 1'b1;
    cyc();
    cyc();
    chk("rd_out2", 32'(dut.outstanding_q), 32'd2);
    mem_gnt_in = 1'b0; redirect_in = 1'b1; redirect_addr_in = 32'h103;
    cyc();
    redirect_in = 1'b0; mem_gnt_in = 1'b1;
    chk("rd_valid", 32'(fetch_valid_out), 32'd0);
    chk("rd_req_drain", 32'(mem_req_out), 32'd0);
    man_rv = 1'b1;
    cyc();
    chk("rd_drop1_valid", 32'(fetch_valid_out), 32'd0);
    chk("rd_drop1_req", 32'(mem_req_out), 32'd0);
    cyc();
    man_rv = 1'b0;
    chk("rd_drop2_valid", 32'(fetch_valid_out), 32'd0);
    chk("rd_req_after", 32'(mem_req_out), 32'd1);
    chk("rd_addr_after", mem_addr_out, 32'h100);
    auto_rv = 1'b1;
    cyc();
    cyc();
    chk("rd_new_valid", 32'(fetch_valid_out), 32'd1);
    chk("rd_new_pc", fetch_pc_out, 32'h100);
    chk("rd_new_ir", fetch_ir_out, word(32'h100));

    // Redirect coinciding with grant and rvalid
    do_reset();
    mem_gnt_in = 1'b1; fetch_ready_in = 1'b1;
    cyc();
    redirect_in = 1'b1; redirect_addr_in = 32'h200;
    cyc();
    redirect_in = 1'b0;
    chk("co_valid", 32'(fetch_valid_out), 32'd0);
    chk("co_req", 32'(mem_req_out), 32'd0);
    chk("co_drop", 32'(dut.drop_q), 32'd1);
    cyc();
    chk("co_valid_after", 32'(fetch_valid_out), 32'd0);
    chk("co_req_after", 32'(mem_req_out), 32'd1);
    chk("co_addr_after", mem_addr_out, 32'h200);
    cyc();
    cyc();
    chk("co_new_pc", fetch_pc_out, 32'h200);

    // Reset mid-stream with a full FIFO
    do_reset();
    mem_gnt_in = 1'b1; fetch_ready_in = 1'b0;
    repeat (5) cyc();
    chk("mr_full_count", 32'(dut.count_q), 32'd4);
    chk("mr_full_valid", 32'(fetch_valid_out), 32'd1);
    reset_in = 1'b0;
    #1;
    chk("mr_req_in_reset", 32'(mem_req_out), 32'd0);
    cyc();
    chk("mr_valid", 32'(fetch_valid_out), 32'd0);
    chk("mr_outstanding", 32'(dut.outstanding_q), 32'd0);
    reset_in = 1'b1;
    #1;
    chk("mr_req_release", 32'(mem_req_out), 32'd1);
    chk("mr_addr_release", mem_addr_out, 32'h0);
    cyc();
    chk("mr_addr_next", mem_addr_out, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
